// File: rtl/if_id_inst_queue_pkg.sv
// Shared widths and field offsets for the fetch/decode instruction queue.
// Optional bypass: define IF_ID_INST_QUEUE_BYPASS_EN.
package if_id_inst_queue_pkg;

  localparam int PC_W_DEF = 32;
  localparam int INST_W = 32;
  localparam int REG_W = 5;

  localparam int IfToIqBusWidth = PC_W_DEF + 33;
  localparam int IqToSpBusWidth = 3 * REG_W + INST_W;

  localparam int RD_LSB = 0;
  localparam int RJ_LSB = 5;
  localparam int RK_LSB = 10;

  typedef struct packed {
    logic [REG_W-1:0] rk;
    logic [REG_W-1:0] rj;
    logic [REG_W-1:0] rd;
  } reg_fields_t;

endpackage

// File: rtl/if_id_inst_queue_inst_field_split.sv
// Splits rk/rj/rd out of an instruction word and packs the decoder bus.
// Purely combinational; reusable by other decode-side stages.
module inst_field_split
  import if_id_inst_queue_pkg::*;
(
  input  logic [INST_W-1:0]         inst_i,
  output logic [IqToSpBusWidth-1:0] bus_o
);

  reg_fields_t f;

  always_comb begin
    f.rd = inst_i[RD_LSB +: REG_W];
    f.rj = inst_i[RJ_LSB +: REG_W];
    f.rk = inst_i[RK_LSB +: REG_W];
  end

  assign bus_o = {f.rk, f.rj, f.rd, inst_i};

endmodule

// File: rtl/if_id_inst_queue.sv
// Fetch-to-decode instruction queue with valid/allowin handshake and flush.
// Optional same-cycle bypass when empty: define IF_ID_INST_QUEUE_BYPASS_EN.
module if_id_inst_queue
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int PC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  output logic                      if_allowin_o,
  input  logic [PC_W-1:0]           if_pc_i,
  input  logic [INST_W-1:0]         if_inst_i,
  input  logic                      if_excp_i,
  output logic                      id_valid_o,
  input  logic                      id_allowin_i,
  output logic [PC_W-1:0]           id_pc_o,
  output logic                      id_excp_o,
  output logic [IqToSpBusWidth-1:0] sp_to_obus,
  output logic [PTR_W:0]            count_o
);

  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic              excp_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic byp;
  logic push;
  logic pop;
  logic q_valid;
  logic [INST_W-1:0] head_inst;

  assign q_valid      = (count_q != '0);
  assign if_allowin_o = (count_q < FULL);

`ifdef IF_ID_INST_QUEUE_BYPASS_EN
  assign byp = !q_valid && if_valid_i;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry taken by decode never touches storage.
  assign push = if_valid_i && if_allowin_o && !flush_i
              && !(byp && id_allowin_i);
  assign pop  = q_valid && id_allowin_i && !flush_i;

  assign id_valid_o = q_valid || byp;
  assign id_pc_o    = byp ? if_pc_i   : pc_q[rd_ptr_q];
  assign id_excp_o  = byp ? if_excp_i : excp_q[rd_ptr_q];
  assign head_inst  = byp ? if_inst_i : inst_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        excp_q[i] <= 1'b0;
      end
    end else if (push) begin
      pc_q[wr_ptr_q]   <= if_pc_i;
      inst_q[wr_ptr_q] <= if_inst_i;
      excp_q[wr_ptr_q] <= if_excp_i;
    end
  end

  inst_field_split u_split (
    .inst_i (head_inst),
    .bus_o  (sp_to_obus)
  );

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Randomised + directed bench for if_id_inst_queue with a queue scoreboard.
// Model: a plain FIFO of entries; the monitor checks at every falling edge.
module tb_if_id_inst_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic        if_allowin_o;
  logic [31:0] if_pc_i = '0;
  logic [31:0] if_inst_i = '0;
  logic        if_excp_i = 1'b0;
  logic        id_valid_o;
  logic        id_allowin_i = 1'b0;
  logic [31:0] id_pc_o;
  logic        id_excp_o;
  logic [46:0] sp_to_obus;
  logic [2:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  if_id_inst_queue #(.DEPTH(4), .PTR_W(2), .PC_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .if_valid_i   (if_valid_i),
    .if_allowin_o (if_allowin_o),
    .if_pc_i      (if_pc_i),
    .if_inst_i    (if_inst_i),
    .if_excp_i    (if_excp_i),
    .id_valid_o   (id_valid_o),
    .id_allowin_i (id_allowin_i),
    .id_pc_o      (id_pc_o),
    .id_excp_o    (id_excp_o),
    .sp_to_obus   (sp_to_obus),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [46:0] bus_of(input logic [31:0] i);
    logic [4:0] rd, rj, rk;
    rd = 5'(i % 32);
    rj = 5'((i / 32) % 32);
    rk = 5'((i / 1024) % 32);
    return {rk, rj, rd, i};
  endfunction

  task automatic cmp_head(input ent_t e);
    chk("head_pc", 64'(id_pc_o), 64'(e.pc));
    chk("head_excp", 64'(id_excp_o), 64'(e.excp));
    chk("head_bus", 64'(sp_to_obus), 64'(bus_of(e.inst)));
  endtask

  // Monitor / scoreboard: sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        int  sz;
        bit  do_pop, do_push, exp_v;
        ent_t inc;
        sz = exp_q.size();
        inc = '{pc: if_pc_i, inst: if_inst_i, excp: if_excp_i};
        exp_v = (sz != 0);
        do_pop = (sz != 0) && id_allowin_i && !flush_i;
        do_push = if_valid_i && (sz < DEPTH) && !flush_i;
`ifdef IF_ID_INST_QUEUE_BYPASS_EN
        if (sz == 0 && if_valid_i) begin
          exp_v = 1'b1;
          cmp_head(inc);
          if (id_allowin_i && !flush_i) do_push = 1'b0;
        end
`endif
        chk("count", 64'(count_o), 64'(sz));
        chk("id_valid", 64'(id_valid_o), 64'(exp_v));
        chk("if_allowin", 64'(if_allowin_o), 64'(sz < DEPTH));
        if (sz != 0) cmp_head(exp_q[0]);
        if (flush_i) exp_q.delete();
        else begin
          if (do_pop) void'(exp_q.pop_front());
          if (do_push) exp_q.push_back(inc);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic ex,
                     input logic alw, input logic fl);
    if_valid_i = v;
    if_pc_i = pc;
    if_inst_i = inst;
    if_excp_i = ex;
    id_allowin_i = alw;
    flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic alw);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, alw, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_valid", 64'(id_valid_o), 64'd0);
    chk("rst_allowin", 64'(if_allowin_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_pc", 64'(id_pc_o), 64'd0);
    chk("rst_bus", 64'(sp_to_obus), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single addi.w push, consumed the following cycle.
    cyc(1'b1, 32'h1C00_0000, 32'h0280_4C21, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", 64'(id_valid_o), 64'd1);
    chk("t1_fields", 64'(sp_to_obus[46:32]),
        64'({5'h13, 5'h01, 5'h01}));
    idle(1'b1);
    idle(1'b1);

    // Fill to full, reject a fifth, then drain in order.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h1C00_0100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Steady stream at occupancy one, wrapping the pointers.
    cyc(1'b1, 32'h1C00_1000, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++)
      cyc(1'b1, 32'h1C00_1000 + 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush at count three with a concurrent push.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h1C00_2000 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1C00_2FFC, $urandom, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Exception entry travels with its PC.
    cyc(1'b1, 32'h1C00_0002, $urandom, 1'b1, 1'b0, 1'b0);
    chk("excp_flag", 64'(id_excp_o), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset at count two.
    cyc(1'b1, 32'h1C00_3000, $urandom, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1C00_3004, $urandom, 1'b0, 1'b0, 1'b0);
    if_valid_i = 1'b0;
    chk("pre_rst_count", 64'(count_o), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(id_valid_o), 64'd0);
    chk("async_rst_count", 64'(count_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b0);

`ifdef IF_ID_INST_QUEUE_BYPASS_EN
    if_valid_i = 1'b1;
    if_pc_i = 32'h1C00_4000;
    if_inst_i = $urandom;
    id_allowin_i = 1'b1;
    #1;
    chk("byp_valid", 64'(id_valid_o), 64'd1);
    @(posedge clk);
    #1;
    chk("byp_count", 64'(count_o), 64'd0);
    idle(1'b0);
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cyc(1'(($urandom % 4) != 0), $urandom, $urandom,
          1'(($urandom % 8) == 0), 1'(($urandom % 3) != 0),
          1'(($urandom % 20) == 0));
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("final_count", 64'(count_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_inst_queue.md
Name: if_id_inst_queue

Overview:
- Instruction queue between fetch and decode.
- Buffers up to DEPTH fetched {pc, inst, excp} entries and decouples fetch stalls from decode stalls with a valid/allowin handshake.
- Extracts register fields rk/rj/rd from the head instruction and presents the packed {rk, rj, rd, inst} bus consumed by the opcode decoder.
- Supports pipeline flush on branch mispredict and exception.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).
- PC_W, 32, program-counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush_i  input  1  discard all entries; from branch/exception resolution.
- if_valid_i  input  1  fetch presents an entry this cycle.
- if_allowin_o  output  1  queue can accept an entry this cycle.
- if_pc_i  input  PC_W  fetched PC.
- if_inst_i  input  32  fetched instruction word.
- if_excp_i  input  1  fetch exception flag (ADEF); entry still enqueued.
- id_valid_o  output  1  head entry valid.
- id_allowin_i  input  1  decode accepts the head entry this cycle.
- id_pc_o  output  PC_W  head PC.
- id_excp_o  output  1  head exception flag.
- sp_to_obus  output  47  packed {rk[4:0], rj[4:0], rd[4:0], inst[31:0]} for the decoder.
- count_o  output  PTR_W+1  current occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count reset to 0; all entry valid bits cleared.
  - id_valid_o=0, if_allowin_o=1, count_o=0.
  - Data outputs 0, because the head storage is cleared.
- Push when if_valid_i && if_allowin_o && !flush_i: entry written at wr_ptr, wr_ptr+1.
- Pop when id_valid_o && id_allowin_i && !flush_i: rd_ptr+1.
- Pointers wrap modulo DEPTH (natural PTR_W overflow).
- if_allowin_o = (count < DEPTH). It is registered-state only, with no combinational path from id_allowin_i. A full queue therefore rejects a push even if a pop occurs the same cycle.
- id_valid_o = (count != 0), registered-state only.
- count update: push&&!pop → +1; pop&&!push → −1; both → unchanged; neither → unchanged.
- Simultaneous push and pop at count==1: head advances to the newly written entry next cycle, so there is no bubble.
- Empty: outputs hold the last stored values. Decode must gate on id_valid_o.
- Full: if_allowin_o=0. Fetch holds its entry, and storage is not overwritten.
- Latency (default build): an entry pushed in cycle N is visible at the head in cycle N+1.
- Field extraction from the head instruction:
  - rd = inst[4:0]
  - rj = inst[9:5]
  - rk = inst[14:10]
- sp_to_obus = {rk, rj, rd, inst}.
- Flush:
  - Pointers and count cleared on the next edge; id_valid_o=0 the following cycle.
  - A push or pop presented in the flush cycle is ignored.
  - if_allowin_o is unaffected in the flush cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); in-flight entries are lost.
- Exception entries (if_excp_i=1) queue normally. id_excp_o travels with its entry, and the inst bits are stored unchanged.

Optional Feature:
- Macro: IF_ID_INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and if_valid_i=1, the head outputs combinationally show the incoming entry, and id_valid_o=if_valid_i.
  - If id_allowin_i=1 in that same cycle, the entry is consumed without being written (zero latency).
  - Flush still blocks the push and the bypass pop.
- Undefined: the strict 1-cycle latency described above, with no combinational fetch→decode path.

Decomposition:
- Shared header (bus-width include):
  - IfToIqBusWidth (PC_W+33).
  - IqToSpBusWidth (47), matching the decoder's input bus.
  - Field offset constants RD_LSB=0, RJ_LSB=5, RK_LSB=10.
- One natural sub-module: inst_field_split. It is combinational, extracts rk/rj/rd from inst and packs sp_to_obus, and can be reused by other decode-side stages.
- Storage and pointer logic stay in the top module.

Test Plan:
- Reset then single push of pc=0x1C000000, inst=0x02804C21 (addi.w) with id_allowin_i=1 → next cycle: id_valid_o=1, rd=1, rj=1, rk=0x13, id_pc_o=0x1C000000; one cycle later id_valid_o=0, count_o=0.
- Fill: push 4 entries with id_allowin_i=0 → count_o=4, if_allowin_o=0. A fifth push is rejected and entry 0 is unchanged at the head. Then pop all with id_allowin_i=1 → entries come out in order pc +0, +4, +8, +C.
- Continuous stream: push and pop every cycle for 20 entries → count_o stays 1 and every PC emerges in order, exercising pointer wrap past 3→0.
- Flush with count=3 plus a concurrent push → next cycle count_o=0, id_valid_o=0; the pushed entry never appears.
- Push with if_excp_i=1, pc=0x1C000002 → id_excp_o=1 at the head with the same pc.
- Assert rst asynchronously mid-stream at count=2 → id_valid_o=0 and count_o=0 before the next clock edge; with IF_ID_INST_QUEUE_BYPASS_EN defined, a push into the empty queue with id_allowin_i=1 shows id_valid_o=1 the same cycle and count_o stays 0.
